// File: rtl/taylor_in_server.sv
`default_nettype none
// taylor_in_server: sample FIFO feeding a round-robin burst server for the rede_taylor core array.
// Rev 1.0: FIFO, round-robin arbiter and IDLE/SEND/GAP burst sequencer.
module taylor_in_server #(
  parameter int N_CORES = 24,
  parameter int DW      = 19,
  parameter int RW      = 4,
  parameter int SELW    = 5,
  parameter int DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [N_CORES*RW-1:0]     req_bus,
  output logic [DW-1:0]             io_in,
  output logic                      in_valid,
  output logic [SELW-1:0]           in_sel,
  output logic                      in_last,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              push, pop;
  logic [SELW-1:0]   last_grant_q, last_grant_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [RW-1:0]     len_q, len_d;
  logic [SELW-1:0]   gnt_idx;
  logic [RW-1:0]     gnt_len;
  logic              gnt_found;
  int                idx;
  logic [DW-1:0]     io_in_q, io_in_d;
  logic              in_valid_q, in_valid_d;
  logic              in_last_q, in_last_d;
  logic [SELW-1:0]   in_sel_q, in_sel_d;

  // Readiness comes from the registered level, so a full FIFO refuses a push even while popping.
  assign s_ready    = (level_q != LW'(DEPTH));
  assign push       = s_valid && s_ready;
  assign pop        = (state_q == SEND) && (level_q != '0);
  assign fifo_level = level_q;
  assign io_in      = io_in_q;
  assign in_valid   = in_valid_q;
  assign in_sel     = in_sel_q;
  assign in_last    = in_last_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Search starts one past the last granted core and wraps modulo N_CORES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_len   = '0;
    idx       = 0;
    for (int i = 1; i <= N_CORES; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!gnt_found && (req_bus[idx*RW +: RW] != '0)) begin
        gnt_found = 1'b1;
        gnt_idx   = SELW'(idx);
        gnt_len   = req_bus[idx*RW +: RW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    len_d        = len_q;
    last_grant_d = last_grant_q;
    io_in_d      = io_in_q;
    in_sel_d     = in_sel_q;
    in_valid_d   = 1'b0;
    in_last_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          sel_d   = gnt_idx;
          len_d   = gnt_len;
          state_d = SEND;
        end
      end
      SEND: begin
        if (pop) begin
          io_in_d    = mem_q[rd_ptr_q];
          in_valid_d = 1'b1;
          in_sel_d   = sel_q;
          len_d      = len_q - RW'(1);
          if (len_q == RW'(1)) begin
            in_last_d = 1'b1;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        last_grant_d = sel_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      len_q        <= '0;
      last_grant_q <= SELW'(N_CORES - 1);
      io_in_q      <= '0;
      in_valid_q   <= 1'b0;
      in_sel_q     <= '0;
      in_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      last_grant_q <= last_grant_d;
      io_in_q      <= io_in_d;
      in_valid_q   <= in_valid_d;
      in_sel_q     <= in_sel_d;
      in_last_q    <= in_last_d;
    end
  end

endmodule
`default_nettype wire
